eth_mac_tx: RTL and testbench

// Transmit half of the Ethernet MAC. Takes frame bytes (dest MAC .. payload) from the TX FIFO

---
 rtl/eth_mac_tx.sv | 196 +++++++++++++++++++
 tb/tb_eth_mac_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit path: preamble/SFD insertion, minimum-length zero padding,
// CRC-32 FCS append and inter-frame gap, driving a byte-wide GMII-style bus.
module eth_mac_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic                  clk_125,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tx_axis_tdata,
  input  logic                  s_tx_axis_tvalid,
  input  logic                  s_tx_axis_tlast,
  input  logic                  s_tx_axis_tuser,
  output logic                  s_tx_axis_trdy,
  output logic [DATA_WIDTH-1:0] gmii_txd,
  output logic                  gmii_txen,
  output logic                  gmii_txer,
  output logic                  tx_busy,
  output logic                  tx_frame_done,
  output logic                  tx_underflow
);

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [10:0] BYTE_CNT_MAX = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    IFG,
    DRAIN
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [10:0]           byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
  logic [31:0]           crc_reg, crc_next, crc_upd, fcs_word;
  logic [7:0]            crc_din;
  logic [DATA_WIDTH-1:0] txd_reg, txd_next;
  logic                  txen_reg, txen_next;
  logic                  txer_reg, txer_next;
  logic                  done_reg, done_next;
  logic                  uf_reg, uf_next;

  // Reflected CRC-32, one byte per clock, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  // PAD feeds zero bytes into the CRC; only PAYLOAD feeds stream data.
  assign crc_din      = (state_reg == PAYLOAD) ? s_tx_axis_tdata[7:0] : 8'h00;
  assign crc_upd      = crc32_byte(crc_reg, crc_din);
  assign fcs_word     = ~crc_reg;
  assign byte_cnt_inc = (byte_cnt_reg == BYTE_CNT_MAX) ? byte_cnt_reg : byte_cnt_reg + 11'd1;

  assign s_tx_axis_trdy = (state_reg == PAYLOAD) || (state_reg == DRAIN);
  assign tx_busy        = (state_reg != IDLE);
  assign gmii_txd       = txd_reg;
  assign gmii_txen      = txen_reg;
  assign gmii_txer      = txer_reg;
  assign tx_frame_done  = done_reg;
  assign tx_underflow   = uf_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    crc_next      = crc_reg;
    txd_next      = '0;
    txen_next     = 1'b0;
    txer_next     = 1'b0;
    done_next     = 1'b0;
    uf_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (s_tx_axis_tvalid) state_next = PREAMBLE;
      end

      PREAMBLE: begin
        txen_next     = 1'b1;
        crc_next      = CRC_INIT;
        byte_cnt_next = 11'd0;
        if (cnt_reg == 8'(PREAMBLE_LEN)) begin
          txd_next   = 8'hD5;
          cnt_next   = 8'd0;
          state_next = PAYLOAD;
        end else begin
          txd_next = 8'h55;
          cnt_next = cnt_reg + 8'd1;
        end
      end

      PAYLOAD: begin
        txen_next = 1'b1;
        if (s_tx_axis_tvalid) begin
          txd_next      = s_tx_axis_tdata;
          crc_next      = crc_upd;
          byte_cnt_next = byte_cnt_inc;
          cnt_next      = 8'd0;
          if (s_tx_axis_tlast) begin
            if (s_tx_axis_tuser) begin
              txer_next  = 1'b1;
              done_next  = 1'b1;
              state_next = IFG;
            end else if (byte_cnt_inc < 11'(MIN_FRAME)) begin
              state_next = PAD;
            end else begin
              state_next = FCS;
            end
          end
        end else begin
          // Source starved mid-frame: poison the byte on the wire and abandon the frame.
          txer_next  = 1'b1;
          done_next  = 1'b1;
          uf_next    = 1'b1;
          state_next = DRAIN;
        end
      end

      PAD: begin
        txen_next     = 1'b1;
        crc_next      = crc_upd;
        byte_cnt_next = byte_cnt_inc;
        if (byte_cnt_inc >= 11'(MIN_FRAME)) begin
          cnt_next   = 8'd0;
          state_next = FCS;
        end
      end

      FCS: begin
        txen_next = 1'b1;
        txd_next  = fcs_word[{cnt_reg[1:0], 3'b000} +: 8];
        cnt_next  = cnt_reg + 8'd1;
        if (cnt_reg[1:0] == 2'd3) begin
          done_next  = 1'b1;
          cnt_next   = 8'd0;
          state_next = IFG;
        end
      end

      IFG: begin
        cnt_next = cnt_reg + 8'd1;
        // A queued frame starts straight from the gap so it is exactly IFG_BYTES long.
        if (cnt_reg == 8'(IFG_BYTES - 1)) begin
          cnt_next   = 8'd0;
          state_next = s_tx_axis_tvalid ? PREAMBLE : IDLE;
        end
      end

      DRAIN: begin
        if (s_tx_axis_tvalid && s_tx_axis_tlast) begin
          cnt_next   = 8'd0;
          state_next = IFG;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      byte_cnt_reg <= 11'd0;
      crc_reg      <= CRC_INIT;
      txd_reg      <= '0;
      txen_reg     <= 1'b0;
      txer_reg     <= 1'b0;
      done_reg     <= 1'b0;
      uf_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      crc_reg      <= crc_next;
      txd_reg      <= txd_next;
      txen_reg     <= txen_next;
      txer_reg     <= txer_next;
      done_reg     <= done_next;
      uf_reg       <= uf_next;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Bench for eth_mac_tx: frame-level expected byte stream built from the frame contents,
// checked against the GMII outputs every clock, plus directed frame scenarios.
module tb_eth_mac_tx;

  logic       clk_125 = 1'b0;
  logic       reset;
  logic [7:0] s_tx_axis_tdata;
  logic       s_tx_axis_tvalid;
  logic       s_tx_axis_tlast;
  logic       s_tx_axis_tuser;
  logic       s_tx_axis_trdy;
  logic [7:0] gmii_txd;
  logic       gmii_txen;
  logic       gmii_txer;
  logic       tx_busy;
  logic       tx_frame_done;
  logic       tx_underflow;

  always #4 clk_125 = ~clk_125;

  eth_mac_tx dut (
    .clk_125          (clk_125),
    .reset            (reset),
    .s_tx_axis_tdata  (s_tx_axis_tdata),
    .s_tx_axis_tvalid (s_tx_axis_tvalid),
    .s_tx_axis_tlast  (s_tx_axis_tlast),
    .s_tx_axis_tuser  (s_tx_axis_tuser),
    .s_tx_axis_trdy   (s_tx_axis_trdy),
    .gmii_txd         (gmii_txd),
    .gmii_txen        (gmii_txen),
    .gmii_txer        (gmii_txer),
    .tx_busy          (tx_busy),
    .tx_frame_done    (tx_frame_done),
    .tx_underflow     (tx_underflow)
  );

  typedef struct {
    logic [7:0] d;
    bit er, done, uf, sfd, first, resid;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] crc_tab [0:255];
  logic [7:0]  frame_buf [0:2047];
  int          idle_run = 0;
  bit          had_end  = 0;
  int          last_gap = -1;
  int          txen_cnt = 0;
  int          last_len = 0;
  logic [31:0] rx_crc   = 32'hFFFFFFFF;

  // Table-driven reflected CRC-32 (poly 0xEDB88320).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    return (c >> 8) ^ crc_tab[c[7:0] ^ b];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit er, input bit done, input bit uf,
                      input bit sfd, input bit first, input bit resid);
    exp_t e;
    e.d = d; e.er = er; e.done = done; e.uf = uf; e.sfd = sfd; e.first = first; e.resid = resid;
    exp_q.push_back(e);
  endtask

  // mode 0: normal, 1: aborted via tuser, 2: underflow after k payload bytes
  task automatic push_expected(input int n, input int mode, input int k);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push(8'h55, 0, 0, 0, 0, (i == 0), 0);
    push(8'hD5, 0, 0, 0, 1, 0, 0);
    if (mode == 2) begin
      for (int i = 0; i < k; i++) push(frame_buf[i], 0, 0, 0, 0, 0, 0);
      push(8'h00, 1, 1, 1, 0, 0, 0);
    end else if (mode == 1) begin
      for (int i = 0; i < n; i++) push(frame_buf[i], (i == n-1), (i == n-1), 0, 0, 0, 0);
    end else begin
      tot = (n > 60) ? n : 60;
      for (int i = 0; i < tot; i++) begin
        b = (i < n) ? frame_buf[i] : 8'h00;
        push(b, 0, 0, 0, 0, 0, 0);
        c = crc_step(c, b);
      end
      c = ~c;
      for (int j = 0; j < 4; j++) push(c[8*j +: 8], 0, (j == 3), 0, 0, 0, (j == 3));
    end
  endtask

  always @(negedge clk_125) begin
    if (gmii_txen) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_byte: got txd=%h txer=%b, required no frame byte", gmii_txd, gmii_txer);
      end else begin
        cur_e = exp_q.pop_front();
        vectors++;
        if (gmii_txd !== cur_e.d || gmii_txer !== cur_e.er || tx_frame_done !== cur_e.done ||
            tx_underflow !== cur_e.uf || tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL byte: got txd=%h er=%b done=%b uf=%b busy=%b, required txd=%h er=%b done=%b uf=%b busy=1",
                   gmii_txd, gmii_txer, tx_frame_done, tx_underflow, tx_busy,
                   cur_e.d, cur_e.er, cur_e.done, cur_e.uf);
        end
        if (cur_e.first) begin
          if (had_end) begin
            vectors++;
            if (idle_run < 12) begin
              errors++;
              $display("FAIL ifg: got %0d idle clocks, required at least 12", idle_run);
            end
          end
          last_gap = had_end ? idle_run : -1;
          had_end  = 0;
          txen_cnt = 0;
        end
        if (cur_e.sfd) rx_crc = 32'hFFFFFFFF;
        else           rx_crc = crc_step(rx_crc, gmii_txd);
        txen_cnt++;
        if (cur_e.resid) begin
          vectors++;
          if (rx_crc !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL crc_residue: got %h, required DEBB20E3", rx_crc);
          end
        end
        if (cur_e.done) begin
          had_end  = 1;
          last_len = txen_cnt;
        end
      end
      idle_run = 0;
    end else begin
      vectors++;
      if (gmii_txd !== 8'h00 || gmii_txer !== 1'b0 || tx_frame_done !== 1'b0 || tx_underflow !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus: got txd=%h er=%b done=%b uf=%b, required all 0",
                 gmii_txd, gmii_txer, tx_frame_done, tx_underflow);
      end
      idle_run++;
    end
  end

  task automatic send_frame(input int n, input int mode, input int k, input int stall,
                            input int reset_at, input bit lat);
    int sent = 0;
    int cyc  = 0;
    bit stalled = 0;
    bit hs;
    while (sent < n) begin
      if (reset_at >= 0 && sent == reset_at) begin
        reset = 1'b1; s_tx_axis_tvalid = 1'b0; s_tx_axis_tlast = 1'b0; s_tx_axis_tuser = 1'b0;
        @(posedge clk_125); #1;
        exp_q.delete();
        chk("reset_midframe", 32'({gmii_txd, gmii_txen, gmii_txer, tx_frame_done, tx_underflow,
                                   tx_busy, s_tx_axis_trdy}), 32'h0);
        reset = 1'b0;
        return;
      end
      if (mode == 2 && sent == k && !stalled) begin
        stalled = 1;
        s_tx_axis_tvalid = 1'b0; s_tx_axis_tlast = 1'b0; s_tx_axis_tuser = 1'b0;
        repeat (stall) @(posedge clk_125);
        #1;
      end
      s_tx_axis_tvalid = 1'b1;
      s_tx_axis_tdata  = frame_buf[sent];
      s_tx_axis_tlast  = (sent == n-1);
      s_tx_axis_tuser  = (mode == 1) && (sent == n-1);
      hs = s_tx_axis_trdy;
      @(posedge clk_125); #1;
      cyc++;
      if (hs) sent++;
      if (lat && cyc == 1) chk("latency_early", 32'(gmii_txen), 32'h0);
      if (lat && cyc == 2) chk("latency_first55", 32'({gmii_txen, gmii_txd}), 32'h155);
      if (cyc > 5000) begin
        errors++;
        $display("FAIL send_timeout: got %0d of %0d bytes accepted, required all", sent, n);
        break;
      end
    end
    s_tx_axis_tvalid = 1'b0; s_tx_axis_tlast = 1'b0; s_tx_axis_tuser = 1'b0;
  endtask

  task automatic run_frame(input int n, input int mode, input int k, input int stall);
    push_expected(n, mode, k);
    send_frame(n, mode, k, stall, -1, 0);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && !tx_busy) begin ok = 1; break; end
      @(posedge clk_125); #1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending busy=%b, required 0 and idle", exp_q.size(), tx_busy);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] c;
    logic [7:0]  ascii [0:8];
    int n, mode, k;

    for (int i = 0; i < 256; i++) begin
      v = 32'(i);
      for (int j = 0; j < 8; j++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end
    reset = 1'b1;
    s_tx_axis_tdata = 8'h00; s_tx_axis_tvalid = 1'b0; s_tx_axis_tlast = 1'b0; s_tx_axis_tuser = 1'b0;
    repeat (3) @(posedge clk_125);
    #1;
    chk("reset_state", 32'({gmii_txd, gmii_txen, gmii_txer, tx_frame_done, tx_underflow,
                            tx_busy, s_tx_axis_trdy}), 32'h0);

    // Pin the model CRC against the standard check value of "123456789".
    for (int i = 0; i < 9; i++) ascii[i] = 8'(8'h31 + i);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, ascii[i]);
    chk("model_crc_check", ~c, 32'hCBF43926);

    reset = 1'b0;
    @(posedge clk_125); #1;

    // 64-byte frame from idle, with first-preamble latency
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i);
    push_expected(64, 0, 0);
    send_frame(64, 0, 0, 0, -1, 1);
    wait_drain();
    chk("t1_txen_clocks", 32'(last_len), 32'd76);

    // 10-byte frame padded to 60
    for (int i = 0; i < 10; i++) frame_buf[i] = 8'(8'hA0 + i);
    push_expected(10, 0, 0);
    chk("t2_model_len", 32'(exp_q.size()), 32'd72);
    send_frame(10, 0, 0, 0, -1, 0);
    wait_drain();
    chk("t2_txen_clocks", 32'(last_len), 32'd72);

    // two 60-byte frames back to back
    for (int i = 0; i < 60; i++) frame_buf[i] = 8'($urandom);
    run_frame(60, 0, 0, 0);
    run_frame(60, 0, 0, 0);
    wait_drain();
    chk("t3_ifg_clocks", 32'(last_gap), 32'd12);
    chk("t3_txen_clocks", 32'(last_len), 32'd72);

    // underflow after 20 payload bytes of a 40-byte frame
    for (int i = 0; i < 40; i++) frame_buf[i] = 8'($urandom);
    run_frame(40, 2, 20, 3);
    wait_drain();
    chk("t4_txen_clocks", 32'(last_len), 32'd29);

    // 70-byte frame aborted with tuser
    for (int i = 0; i < 70; i++) frame_buf[i] = 8'($urandom);
    run_frame(70, 1, 0, 0);
    wait_drain();
    chk("t5_txen_clocks", 32'(last_len), 32'd78);

    // reset at payload byte 30, then a clean frame
    for (int i = 0; i < 60; i++) frame_buf[i] = 8'($urandom);
    push_expected(60, 0, 0);
    send_frame(60, 0, 0, 0, 30, 0);
    repeat (2) @(posedge clk_125);
    #1;
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'($urandom);
    run_frame(64, 0, 0, 0);
    wait_drain();
    chk("t6_txen_clocks", 32'(last_len), 32'd76);

    // randomized traffic
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 100);
      for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
      mode = 0; k = 0;
      case ($urandom_range(0, 9))
        0: mode = 1;
        1: if (n >= 2) begin mode = 2; k = $urandom_range(1, n-1); end
        default: mode = 0;
      endcase
      run_frame(n, mode, k, $urandom_range(1, 4));
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 30)) @(posedge clk_125);
        #1;
      end
    end
    wait_drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
